// File: rtl/lsu_queue.sv
// In-order load/store queue between EX/MEM and the data-memory port; drives load writeback.
// Optional `LSU_FLUSH_EN` adds flush_i, which discards all not-yet-sent entries.
module lsu_queue #(
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned rd_width_p   = 5,
  parameter int unsigned depth_p      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef LSU_FLUSH_EN
  input  logic                    flush_i,
`endif
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic                    issue_wen_i,
  input  logic                    issue_byte_i,
  input  logic [addr_width_p-1:0] issue_addr_i,
  input  logic [data_width_p-1:0] issue_data_i,
  input  logic [rd_width_p-1:0]   issue_rd_i,
  output logic                    mem_valid_o,
  output logic                    mem_wen_o,
  output logic                    mem_byte_o,
  output logic [addr_width_p-1:0] mem_addr_o,
  output logic [data_width_p-1:0] mem_wdata_o,
  input  logic                    mem_yumi_i,
  input  logic                    mem_rvalid_i,
  input  logic [data_width_p-1:0] mem_rdata_i,
  output logic                    mem_yumi_o,
  output logic                    wb_valid_o,
  output logic [rd_width_p-1:0]   wb_rd_o,
  output logic [data_width_p-1:0] wb_data_o,
  input  logic                    wb_ready_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned ptr_w_lp = $clog2(depth_p) + 1;
  localparam int unsigned idx_w_lp = ptr_w_lp - 1;

  typedef logic [ptr_w_lp-1:0] ptr_t;
  localparam ptr_t depth_lp = ptr_t'(depth_p);
  localparam ptr_t one_lp   = ptr_t'(1);

  logic [depth_p-1:0]      wen_q;
  logic [depth_p-1:0]      byte_q;
  logic [addr_width_p-1:0] addr_q  [depth_p];
  logic [data_width_p-1:0] wdata_q [depth_p];
  logic [rd_width_p-1:0]   rd_q    [depth_p];

  ptr_t tail_q, send_q, head_q;
  ptr_t count;
  logic err_q;
  logic flush;
  logic issue_fire;
  logic send_fire;
  logic outstanding;
  logic head_store;

  logic [idx_w_lp-1:0] tail_idx, send_idx, head_idx;

`ifdef LSU_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign tail_idx = tail_q[idx_w_lp-1:0];
  assign send_idx = send_q[idx_w_lp-1:0];
  assign head_idx = head_q[idx_w_lp-1:0];

  always_comb begin
    count         = tail_q - head_q;
    // Registered occupancy only: a same-cycle retire does not free a slot for issue.
    issue_ready_o = (count < depth_lp) && !flush;
    issue_fire    = issue_valid_i && issue_ready_o;

    mem_valid_o   = (send_q != tail_q) && !flush;
    mem_wen_o     = wen_q[send_idx];
    mem_byte_o    = byte_q[send_idx];
    mem_addr_o    = addr_q[send_idx];
    mem_wdata_o   = wdata_q[send_idx];
    send_fire     = mem_yumi_i && mem_valid_o;

    outstanding   = (head_q != send_q);
    head_store    = wen_q[head_idx];
    wb_valid_o    = mem_rvalid_i && !head_store;
    wb_rd_o       = rd_q[head_idx];
    wb_data_o     = mem_rdata_i;
    if (byte_q[head_idx]) begin
      wb_data_o      = '0;
      wb_data_o[7:0] = mem_rdata_i[7:0];
    end
    mem_yumi_o    = mem_rvalid_i && outstanding && (head_store || wb_ready_i);

    busy_o        = (count != '0);
    err_o         = err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < depth_p; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        rd_q[i]    <= '0;
      end
      wen_q  <= '0;
      byte_q <= '0;
    end else if (issue_fire) begin
      wen_q[tail_idx]   <= issue_wen_i;
      byte_q[tail_idx]  <= issue_byte_i;
      addr_q[tail_idx]  <= issue_addr_i;
      wdata_q[tail_idx] <= issue_data_i;
      rd_q[tail_idx]    <= issue_rd_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tail_q <= '0;
      send_q <= '0;
      head_q <= '0;
      err_q  <= 1'b0;
    end else begin
      // Flush rewinds tail onto send; send cannot move that cycle since mem_valid_o is low.
      if (flush)
        tail_q <= send_q;
      else if (issue_fire)
        tail_q <= tail_q + one_lp;
      if (send_fire)
        send_q <= send_q + one_lp;
      if (mem_yumi_o)
        head_q <= head_q + one_lp;
      if ((mem_rvalid_i && !outstanding) || (mem_yumi_i && !mem_valid_o))
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_queue.sv
// Self-checking bench for lsu_queue: vector table, directed corner sequences, random vs queue model.
module tb_lsu_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
`ifdef LSU_FLUSH_EN
  logic        flush_i;
`endif
  logic        issue_valid_i, issue_ready_o, issue_wen_i, issue_byte_i;
  logic [31:0] issue_addr_i, issue_data_i;
  logic [4:0]  issue_rd_i;
  logic        mem_valid_o, mem_wen_o, mem_byte_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_yumi_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_yumi_o, wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_ready_i, busy_o, err_o;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_queue #(.addr_width_p(32), .data_width_p(32), .rd_width_p(5), .depth_p(DEPTH)) dut (
    .clk(clk), .reset(reset),
`ifdef LSU_FLUSH_EN
    .flush_i(flush_i),
`endif
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_wen_i(issue_wen_i), .issue_byte_i(issue_byte_i),
    .issue_addr_i(issue_addr_i), .issue_data_i(issue_data_i), .issue_rd_i(issue_rd_i),
    .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_yumi_i(mem_yumi_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_yumi_o(mem_yumi_o),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .wb_ready_i(wb_ready_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wen;
    logic        byte_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_wb;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        wen;
    logic        byte_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } op_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_wen_i = 0; issue_byte_i = 0;
    issue_addr_i = '0; issue_data_i = '0; issue_rd_i = '0;
    mem_yumi_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; wb_ready_i = 1;
`ifdef LSU_FLUSH_EN
    flush_i = 0;
`endif
  endtask

  task automatic do_reset();
    reset = 0;
    #2;
    reset = 1;
    tick();
  endtask

  task automatic issue_load(input logic [31:0] addr, input logic [4:0] rd);
    issue_valid_i = 1; issue_wen_i = 0; issue_byte_i = 0;
    issue_addr_i = addr; issue_rd_i = rd; issue_data_i = '0;
  endtask

  // Sends all n pending entries, then returns n responses.
  task automatic drain(input int n);
    int sent = 0;
    int guard = 0;
    idle();
    while (sent < n && guard < 50) begin
      mem_yumi_i = mem_valid_o;
      if (mem_valid_o) sent++;
      tick();
      guard++;
    end
    mem_yumi_i = 0;
    for (int k = 0; k < n; k++) begin
      mem_rvalid_i = 1; mem_rdata_i = 32'h1000 + k;
      tick();
    end
    mem_rvalid_i = 0;
    #2;
    chk("drain_busy", busy_o, 0);
    chk("drain_err", err_o, 0);
  endtask

  vec_t vecs[6];
  op_t  mq[$];
  int   nsent;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,      5'd3,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h41,  32'h0,      5'd4,  32'h12345678, 1'b1, 32'h00000078};
    vecs[2] = '{1'b1, 1'b0, 32'h80,  32'hA5A5A5A5, 5'd0, 32'h0,       1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h83,  32'h000000EE, 5'd0, 32'h0,       1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 32'h1FF, 32'h0,      5'd31, 32'hFFFFFF80, 1'b1, 32'h00000080};
    vecs[5] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 5'd17, 32'h0BADF00D, 1'b1, 32'h0BADF00D};

    idle();
    reset = 0;
    #12;
    chk("rst_issue_ready", issue_ready_o, 1);
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_mem_yumi", mem_yumi_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    reset = 1;
    tick();

    // Table: one full round trip per vector.
    for (int i = 0; i < 6; i++) begin
      idle();
      issue_valid_i = 1; issue_wen_i = vecs[i].wen; issue_byte_i = vecs[i].byte_op;
      issue_addr_i = vecs[i].addr; issue_data_i = vecs[i].wdata; issue_rd_i = vecs[i].rd;
      #2;
      chk("tv_ready", issue_ready_o, 1);
      chk("tv_no_bypass", mem_valid_o, 0);
      tick();
      idle();
      #2;
      chk("tv_mem_valid", mem_valid_o, 1);
      chk("tv_mem_wen", mem_wen_o, vecs[i].wen);
      chk("tv_mem_byte", mem_byte_o, vecs[i].byte_op);
      chk("tv_mem_addr", mem_addr_o, vecs[i].addr);
      if (vecs[i].wen) chk("tv_mem_wdata", mem_wdata_o, vecs[i].wdata);
      mem_yumi_i = 1;
      tick();
      idle();
      #2;
      chk("tv_sent", mem_valid_o, 0);
      chk("tv_busy", busy_o, 1);
      tick();
      mem_rvalid_i = 1; mem_rdata_i = vecs[i].rdata;
      #2;
      chk("tv_rsp_yumi", mem_yumi_o, 1);
      chk("tv_wb_valid", wb_valid_o, vecs[i].exp_wb);
      if (vecs[i].exp_wb) begin
        chk("tv_wb_rd", wb_rd_o, vecs[i].rd);
        chk("tv_wb_data", wb_data_o, vecs[i].exp_data);
      end
      tick();
      idle();
      #2;
      chk("tv_idle_busy", busy_o, 0);
    end

    // Fill to depth with memory stalled, then retire+issue in one cycle.
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      issue_load(32'h100 + 4 * i, 5'(i + 1));
      #2;
      chk("fill_ready", issue_ready_o, 1);
      tick();
    end
    idle();
    #2;
    chk("full_ready", issue_ready_o, 0);
    chk("full_busy", busy_o, 1);
    chk("full_addr", mem_addr_o, 32'h100);
    mem_yumi_i = 1;
    tick();
    idle();
    mem_rvalid_i = 1; mem_rdata_i = 32'h55; issue_load(32'h200, 5'd9);
    #2;
    chk("full_retire_yumi", mem_yumi_o, 1);
    chk("full_retire_wb_rd", wb_rd_o, 1);
    chk("full_retire_ready", issue_ready_o, 0);
    tick();
    mem_rvalid_i = 0;
    #2;
    chk("after_retire_ready", issue_ready_o, 1);
    tick();
    idle();
    #2;
    chk("refull_ready", issue_ready_o, 0);
    drain(DEPTH);

    // Writeback port held for three cycles.
    idle();
    issue_load(32'h300, 5'd7);
    tick();
    idle();
    mem_yumi_i = 1;
    tick();
    idle();
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D; wb_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall_yumi", mem_yumi_o, 0);
      chk("stall_wb_valid", wb_valid_o, 1);
      chk("stall_busy", busy_o, 1);
      tick();
    end
    wb_ready_i = 1;
    #2;
    chk("stall_release_yumi", mem_yumi_o, 1);
    chk("stall_release_rd", wb_rd_o, 7);
    chk("stall_release_data", wb_data_o, 32'hCAFEF00D);
    tick();
    idle();
    #2;
    chk("stall_done_busy", busy_o, 0);
    chk("stall_done_err", err_o, 0);

    // Spurious response while idle sets a sticky error.
    mem_rvalid_i = 1;
    tick();
    idle();
    #2;
    chk("spur_err", err_o, 1);
    tick(); tick();
    chk("spur_err_sticky", err_o, 1);
    do_reset();
    chk("spur_err_cleared", err_o, 0);

    // Yumi without a presented request is also an error.
    mem_yumi_i = 1;
    tick();
    idle();
    #2;
    chk("yumi_err", err_o, 1);
    do_reset();

    // Reset mid-operation drops entries; the stale response is then an error.
    issue_load(32'h400, 5'd2);
    tick();
    tick();
    idle();
    mem_yumi_i = 1;
    tick();
    idle();
    reset = 0;
    #1;
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_valid", mem_valid_o, 0);
    reset = 1;
    tick();
    mem_rvalid_i = 1;
    tick();
    idle();
    #2;
    chk("rstmid_stale_err", err_o, 1);
    do_reset();

`ifdef LSU_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      issue_load(32'h500 + 4 * i, 5'(10 + i));
      tick();
    end
    idle();
    mem_yumi_i = 1;
    tick();
    idle();
    flush_i = 1; issue_load(32'h600, 5'd20);
    #2;
    chk("flush_valid", mem_valid_o, 0);
    chk("flush_ready", issue_ready_o, 0);
    tick();
    idle();
    #2;
    chk("post_flush_valid", mem_valid_o, 0);
    chk("post_flush_busy", busy_o, 1);
    mem_rvalid_i = 1; mem_rdata_i = 32'h77;
    #2;
    chk("flush_wb_valid", wb_valid_o, 1);
    chk("flush_wb_rd", wb_rd_o, 10);
    tick();
    idle();
    #2;
    chk("flush_done_busy", busy_o, 0);
    chk("flush_err", err_o, 0);
`endif

    // Random traffic against an in-order queue model.
    do_reset();
    mq.delete();
    nsent = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic exp_ready, exp_mvalid, exp_yumi_o, exp_wb;
      logic [31:0] exp_data;
      op_t nop;
      nop.wen = 1'($urandom); nop.byte_op = 1'($urandom);
      nop.addr = $urandom; nop.wdata = $urandom; nop.rd = 5'($urandom);
      issue_valid_i = ($urandom_range(0, 1) == 1);
      issue_wen_i = nop.wen; issue_byte_i = nop.byte_op;
      issue_addr_i = nop.addr; issue_data_i = nop.wdata; issue_rd_i = nop.rd;
      mem_yumi_i   = (nsent < mq.size()) && ($urandom_range(0, 2) != 0);
      mem_rvalid_i = (nsent > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata_i  = $urandom;
      wb_ready_i   = ($urandom_range(0, 3) != 0);
      #2;
      exp_ready  = mq.size() < DEPTH;
      exp_mvalid = nsent < mq.size();
      exp_yumi_o = mem_rvalid_i && (mq[0].wen || wb_ready_i);
      exp_wb     = mem_rvalid_i && !mq[0].wen;
      exp_data   = mq[0].byte_op ? {24'h0, mem_rdata_i[7:0]} : mem_rdata_i;
      chk("rnd_ready", issue_ready_o, exp_ready);
      chk("rnd_mem_valid", mem_valid_o, exp_mvalid);
      chk("rnd_busy", busy_o, mq.size() != 0);
      chk("rnd_err", err_o, 0);
      if (exp_mvalid) begin
        chk("rnd_mem_addr", mem_addr_o, mq[nsent].addr);
        chk("rnd_mem_wen", mem_wen_o, mq[nsent].wen);
        chk("rnd_mem_byte", mem_byte_o, mq[nsent].byte_op);
        if (mq[nsent].wen) chk("rnd_mem_wdata", mem_wdata_o, mq[nsent].wdata);
      end
      if (mem_rvalid_i) begin
        chk("rnd_mem_yumi_o", mem_yumi_o, exp_yumi_o);
        chk("rnd_wb_valid", wb_valid_o, exp_wb);
        if (exp_wb) begin
          chk("rnd_wb_rd", wb_rd_o, mq[0].rd);
          chk("rnd_wb_data", wb_data_o, exp_data);
        end
      end else begin
        chk("rnd_no_rsp", {wb_valid_o, mem_yumi_o}, 2'b00);
      end
      if (mem_yumi_i) nsent++;
      if (exp_yumi_o) begin
        void'(mq.pop_front());
        nsent--;
      end
      if (issue_valid_i && exp_ready) mq.push_back(nop);
      tick();
    end
    drain(mq.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
